// File: rtl/commit_store_buffer.sv
// commit_store_buffer: in-order post-commit store buffer with cache drain FSM and store-to-load forwarding
module commit_store_buffer #(
    parameter int SB_ENTRIES   = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int ADDR_BITS    = 64,
    parameter int WORD_SIZE    = 64
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              flush_in,
    input  logic [COMMIT_WIDTH-1:0]           str_valid_in,
    input  logic [COMMIT_WIDTH*ADDR_BITS-1:0] str_addr_in,
    input  logic [COMMIT_WIDTH*WORD_SIZE-1:0] str_data_in,
    output logic [$clog2(SB_ENTRIES+1)-1:0]   free_out,
    output logic                              empty_out,
    output logic                              overflow_err_out,
    output logic                              mem_req_valid_out,
    input  logic                              mem_req_ready_in,
    output logic [ADDR_BITS-1:0]              mem_req_addr_out,
    output logic [WORD_SIZE-1:0]              mem_req_data_out,
    input  logic                              mem_ack_in,
    input  logic [ADDR_BITS-1:0]              ld_addr_in,
    output logic                              ld_hit_out,
    output logic [WORD_SIZE-1:0]              ld_data_out
);
    localparam int PTR_W = $clog2(SB_ENTRIES);
    localparam int CNT_W = $clog2(SB_ENTRIES+1);
    localparam logic [ADDR_BITS-1:0] DW_MASK = ~(ADDR_BITS'(WORD_SIZE/8 - 1));

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

    logic [ADDR_BITS-1:0] addr_q [SB_ENTRIES];
    logic [WORD_SIZE-1:0] data_q [SB_ENTRIES];
    logic [PTR_W-1:0]     head_q, tail_q, fwd_idx;
    logic [CNT_W-1:0]     count_q, count_d, free_q, acc;
    logic                 ovf_q, drop, pop, req_valid_q;
    state_t               state_q;
    logic                 wr_en  [COMMIT_WIDTH];
    logic [PTR_W-1:0]     wr_idx [COMMIT_WIDTH];
    logic                 unused_flush;

    // entries are architectural, so a pipeline flush deliberately touches nothing
    assign unused_flush = flush_in;

    assign pop               = (state_q == WAIT_ACK) && mem_ack_in;
    assign count_d           = count_q + acc - CNT_W'(pop);
    assign free_out          = free_q;
    assign overflow_err_out  = ovf_q;
    assign empty_out         = (count_q == '0) && (state_q == IDLE);
    assign mem_req_valid_out = req_valid_q;
    assign mem_req_addr_out  = req_valid_q ? (addr_q[head_q] & DW_MASK) : '0;
    assign mem_req_data_out  = req_valid_q ? data_q[head_q] : '0;

    // compact valid slots into the tail, older slots first; anything beyond the free space is dropped
    always_comb begin
        acc  = '0;
        drop = 1'b0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            wr_idx[j] = tail_q + PTR_W'(acc);
            wr_en[j]  = str_valid_in[j] && (acc < free_q);
            drop      = drop | (str_valid_in[j] && !wr_en[j]);
            acc       = acc + CNT_W'(wr_en[j]);
        end
    end

    // entry storage; no reset needed since validity comes from head/count
    always_ff @(posedge clk_in) begin
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (wr_en[j]) begin
                addr_q[wr_idx[j]] <= str_addr_in[j*ADDR_BITS +: ADDR_BITS];
                data_q[wr_idx[j]] <= str_data_in[j*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // pointers, occupancy, registered free count and sticky overflow flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= CNT_W'(SB_ENTRIES);
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(acc);
            count_q <= count_d;
            free_q  <= CNT_W'(SB_ENTRIES) - count_d;
            ovf_q   <= ovf_q | drop;
        end
    end

    // drain FSM: one outstanding cache write at a time, head popped only on ack
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (count_q != '0) begin
                    state_q     <= SEND;
                    req_valid_q <= 1'b1;
                end
                SEND: if (mem_req_ready_in) begin
                    state_q     <= WAIT_ACK;
                    req_valid_q <= 1'b0;
                end
                WAIT_ACK: if (mem_ack_in) begin
                    state_q     <= (count_d != '0) ? SEND : IDLE;
                    req_valid_q <= (count_d != '0);
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // youngest-match forwarding: scan oldest to youngest so later matches win
    always_comb begin
        ld_hit_out  = 1'b0;
        ld_data_out = '0;
        fwd_idx     = head_q;
        for (int k = 0; k < SB_ENTRIES; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && ((addr_q[fwd_idx] & DW_MASK) == (ld_addr_in & DW_MASK))) begin
                ld_hit_out  = 1'b1;
                ld_data_out = data_q[fwd_idx];
            end
        end
    end
endmodule

// File: doc/commit_store_buffer.md
# commit_store_buffer

Post-commit store buffer sitting directly downstream of the reorder buffer's commit port. Accepts up to two retired stores per cycle (address and data already read from the register file), holds them in program order, and drains them one at a time to the L1 data cache over a valid/ready request plus ack handshake. Provides youngest-match store-to-load forwarding for the LSU and a free-slot count that the ROB uses to throttle store commit.

## Interface
Parameters:
- SB_ENTRIES, 8, buffer depth (power of two, ≥2)
- COMMIT_WIDTH, 2, stores accepted per cycle
- ADDR_BITS, 64, address width
- WORD_SIZE, 64, store data width (bytes per store = WORD_SIZE/8)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous, active-high reset
- flush_in  input  1  pipeline flush; does not affect buffer contents (entries are architectural)
- str_valid_in  input  COMMIT_WIDTH  per-slot committed store valid; slot 0 older than slot 1
- str_addr_in  input  COMMIT_WIDTH×ADDR_BITS  store addresses
- str_data_in  input  COMMIT_WIDTH×WORD_SIZE  store data
- free_out  output  $clog2(SB_ENTRIES+1)  free slots, registered
- empty_out  output  1  no entries held and FSM IDLE
- overflow_err_out  output  1  sticky: commit offered more stores than free_out
- mem_req_valid_out  output  1  drain request valid
- mem_req_ready_in  input  1  cache accepts request
- mem_req_addr_out  output  ADDR_BITS  head entry address
- mem_req_data_out  output  WORD_SIZE  head entry data
- mem_ack_in  input  1  cache write complete
- ld_addr_in  input  ADDR_BITS  LSU load lookup address
- ld_hit_out  output  1  a buffered store matches
- ld_data_out  output  WORD_SIZE  forwarded data (youngest match)

## Operation
- Circular buffer, head/tail pointers $clog2(SB_ENTRIES) bits, wrap naturally; count register $clog2(SB_ENTRIES+1) bits.
- Enqueue: valid slots compacted in slot order into tail; 2'b10 enqueues only slot 1 at tail. Accepted count limited to free_out sampled at cycle start; excess slots (youngest first) dropped and overflow_err_out set until reset.
- Space freed by a pop is not reusable in the same cycle.
- Addresses are doubleword granular: bits [$clog2(WORD_SIZE/8)-1:0] ignored for forwarding and zeroed on mem_req_addr_out.
- Drain FSM:
  - IDLE: to SEND when count≠0.
  - SEND: mem_req_valid_out=1, addr/data from head, held stable until mem_req_ready_in; on valid&&ready to WAIT_ACK. mem_ack_in ignored.
  - WAIT_ACK: on mem_ack_in pop head (head+1, count−1); to SEND if count−1+enqueued≠0, else IDLE.
- Head entry remains forwardable until popped.
- Forwarding combinational: compare ld_addr_in doubleword with every valid entry; youngest (closest to tail) match drives ld_data_out; no match → ld_hit_out=0, ld_data_out=0.
- flush_in has no effect on state or outputs.
- count'(next) = count + accepted − popped; enqueue and pop in same cycle allowed.

## Timing
- Reset: head=tail=count=0, FSM IDLE, free_out=SB_ENTRIES, empty_out=1, overflow_err_out=0, mem_req_valid_out=0, mem_req_addr_out=0, mem_req_data_out=0, ld_hit_out=0, ld_data_out=0.
- Reset mid-WAIT_ACK discards all entries; a later mem_ack_in in IDLE is ignored.
- Store accepted on edge E0: free_out/ld_hit_out reflect it after E0; FSM enters SEND at E1; mem_req_valid_out high from E1.
- Single store, ready and ack each asserted one cycle after valid: pop at E3; empty_out=1 after E3.
- Back-to-back drain: ack on edge Ek → next request valid after Ek (no IDLE bubble).
- Full (count=SB_ENTRIES): free_out=0; any str_valid_in bit sets overflow_err_out next edge; no state corruption.

## Test plan
- Reset then commit slot0 addr 0x1000 data 0xAA at E0 → free_out 7 after E0; mem_req_valid_out from E1 with addr 0x1000 data 0xAA; ready+ack → empty_out=1, free_out 8.
- Commit pairs to 0x2000/0x2008 four cycles, ready held low → free_out 0; fifth commit → overflow_err_out=1, drains show exactly eight stores in order.
- Commit 0x3000=0x11 then 0x3004=0x22 → ld_addr_in 0x3000 gives ld_hit_out=1, ld_data_out 0x22; 0x4000 gives hit 0.
- Hold mem_req_ready_in low 5 cycles → addr/data stable; ack during SEND ignored.
- Wrap: 20 stores with random ready/ack delays → drain order matches commit order, count never exceeds 8.
- flush_in pulse with 3 entries buffered → all 3 still drained; rst_in in WAIT_ACK → empty_out=1 next cycle, stray ack ignored.
